cnn_datapath_arbiter: RTL and testbench
=======================================

Name: cnn_datapath_arbiter

Overview:
- Two-requester round-robin arbiter that shares one INTERNAL_BITS-wide datapath between two producers, e.g. the weight fetch and feature fetch paths feeding the CNN PE.
- Drives the `sel` of the shared 2-to-1 data multiplexer.
- Holds a grant for the whole burst.
- Registers the selected word into a single-entry output stage with valid/ready handshake.

Parameters:
- DATA_W, `INTERNAL_BITS (32): width of data words and of the muxed path.
- MAX_BURST, 16: maximum beats per grant before forced release (fairness cap); legal range 1..255.

Ports:
- Interface: one clock (`clk`); reset (`reset`) is synchronous and active-high.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid0  input  1  requester 0 has a word.
- in_data0  input  DATA_W  requester 0 word.
- in_last0  input  1  requester 0 word is last of burst.
- in_ready0  output  1  requester 0 word accepted this cycle when in_valid0 is also high.
- in_valid1 / in_data1 / in_last1 / in_ready1  same as above, for requester 1.
- sel  output  1  mux select: 0 = requester 0 (Data_in1), 1 = requester 1 (Data_in2).
- out_valid  output  1  out_data holds a valid word.
- out_data  output  DATA_W  registered selected word.
- out_last  output  1  registered last flag of out_data.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  a grant is active (state != IDLE).

Behaviour:
- Reset values: state=IDLE, sel=0, prio=0 (requester 0 wins first tie), beat_cnt=0, out_valid=0, out_data=0, out_last=0, busy=0. in_ready0/1 are 0 during reset.
- Reset mid-burst discards any held word and grant; no partial state survives.
- States are IDLE, GNT0 and GNT1.
- sel is a registered output:
  - 0 in GNT0, 1 in GNT1.
  - In IDLE it holds its last value.
- IDLE transitions:
  - Only in_valid0 high → GNT0 next cycle.
  - Only in_valid1 high → GNT1 next cycle.
  - Both high → GNTprio next cycle.
  - Neither high → stay in IDLE.
  - Arbitration costs one bubble cycle. No word is accepted in IDLE.
- Output stage has space when `space = !out_valid || out_ready`.
- In GNTi: in_ready_i = space; in_ready of the other requester = 0.
- A beat transfers when in_valid_i && in_ready_i. On a transfer:
  - out_data ← in_data_i, out_last ← in_last_i, out_valid ← 1.
  - beat_cnt ← beat_cnt+1.
- If out_valid && out_ready and no transfer occurs, out_valid ← 0.
- Simultaneous drain and fill in the same cycle gives full throughput: 1 word/cycle.
- Grant release happens on a transfer with in_last_i=1, or on a transfer where beat_cnt == MAX_BURST-1. On release:
  - state ← IDLE, beat_cnt ← 0, prio ← ~i.
  - Forced release does not assert out_last.
- Latency: a word accepted in cycle N appears on out_data/out_valid in cycle N+1.
- out_data, out_last and out_valid hold stable while out_valid && !out_ready.
- in_valid dropping mid-burst keeps the grant (no timeout); the arbiter waits for that requester.
- beat_cnt width is $clog2(MAX_BURST)+1. It never wraps because release occurs at MAX_BURST.

Test Plan:
- Single requester: reset, then req0 sends 3 words 0xA0,0xA1,0xA2 (last on 0xA2) with out_ready=1.
  - GNT0 one cycle after in_valid0.
  - out_data shows 0xA0..0xA2 on consecutive cycles with out_last on 0xA2.
  - Then IDLE and prio=1.
- Tie and round-robin: both requesters continuously send 2-word bursts (0x1x / 0x2x) after reset.
  - Grant order is 0,1,0,1.
  - sel toggles accordingly.
  - Every burst appears contiguously on out_data.
- Backpressure: during a req1 burst, hold out_ready=0 for 4 cycles.
  - in_ready1=0 after one word is buffered.
  - out_data holds its value unchanged.
  - No word is lost or duplicated after out_ready returns to 1.
- Burst cap: MAX_BURST=4; req0 sends 6 words with no last while req1 is pending.
  - Release after 4 beats; req1 is granted next.
  - req0's remaining 2 words go through a later grant.
  - out_last is never set for req0.
- Reset mid-burst: assert reset after 2 beats of a req0 burst with out_valid=1.
  - Next cycle: out_valid=0, busy=0, sel=0, prio=0.
  - A fresh tie then grants req0.
- Idle gap: req1 valid drops for 3 cycles mid-burst.
  - State stays GNT1 and in_ready0 stays 0.
  - The burst completes once in_valid1 returns.

Source files
------------

// File: rtl/cnn_datapath_arbiter.sv
// rtl/cnn_datapath_arbiter.sv - two-requester round-robin burst arbiter with registered output stage
module cnn_datapath_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid0,
  input  logic [DATA_W-1:0] in_data0,
  input  logic              in_last0,
  output logic              in_ready0,
  input  logic              in_valid1,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              in_last1,
  output logic              in_ready1,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t             state, state_d;
  logic               prio, prio_d;
  logic               sel_d;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_d;
  logic               space;
  logic               xfer0, xfer1, xfer;
  logic [DATA_W-1:0]  xfer_data;
  logic               xfer_last;
  logic               at_cap;
  logic               release_grant;

  // The output stage can take a word when empty or when it drains this cycle.
  assign space     = !out_valid || out_ready;
  assign in_ready0 = !reset && (state == GNT0) && space;
  assign in_ready1 = !reset && (state == GNT1) && space;
  assign busy      = (state != IDLE);

  assign xfer0     = in_valid0 && in_ready0;
  assign xfer1     = in_valid1 && in_ready1;
  assign xfer      = xfer0 || xfer1;
  assign xfer_data = xfer1 ? in_data1 : in_data0;
  assign xfer_last = xfer1 ? in_last1 : in_last0;

  assign at_cap        = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign release_grant = xfer && (xfer_last || at_cap);

  always_comb begin
    state_d    = state;
    prio_d     = prio;
    sel_d      = sel;
    beat_cnt_d = beat_cnt;
    unique case (state)
      IDLE: begin
        if (in_valid0 && (!in_valid1 || !prio)) begin
          state_d = GNT0;
        end else if (in_valid1) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (release_grant) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          prio_d     = (state == GNT0);
        end else if (xfer) begin
          beat_cnt_d = beat_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // sel follows the granted requester and holds its last value through IDLE.
    if (state_d == GNT0) begin
      sel_d = 1'b0;
    end else if (state_d == GNT1) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio     <= 1'b0;
      sel      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      prio     <= prio_d;
      sel      <= sel_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_last  <= xfer_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_datapath_arbiter.sv
// tb/tb_cnn_datapath_arbiter.sv - self-checking bench for cnn_datapath_arbiter
module tb_cnn_datapath_arbiter;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic v0;
    logic v1;
    logic exp_busy;
    logic exp_sel;
    logic exp_r0;
    logic exp_r1;
  } arb_vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid0 = 1'b0, in_last0 = 1'b0, in_ready0;
  logic              in_valid1 = 1'b0, in_last1 = 1'b0, in_ready1;
  logic [DATA_W-1:0] in_data0 = '0, in_data1 = '0;
  logic              sel, out_valid, out_last, busy;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b1;

  beat_t             src0[$], src1[$], exp_q[$];
  logic [DATA_W-1:0] out_log[$];
  logic              grant_log[$];
  logic [DATA_W-1:0] want_q[$];
  logic              gap0 = 1'b0, gap1 = 1'b0;
  logic              prev_ov = 1'b0, prev_or = 1'b0, prev_busy = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  int                n_checks = 0;
  int                n_pass = 0;
  arb_vec_t          tbl[4];

  cnn_datapath_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .in_valid0(in_valid0), .in_data0(in_data0), .in_last0(in_last0), .in_ready0(in_ready0),
    .in_valid1(in_valid1), .in_data1(in_data1), .in_last1(in_last1), .in_ready1(in_ready1),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input logic [DATA_W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Drive from the source queues, then sample at the falling edge.
  task automatic cycle();
    beat_t e;
    in_valid0 = !gap0 && (src0.size() > 0);
    in_data0  = in_valid0 ? src0[0].data : '0;
    in_last0  = in_valid0 ? src0[0].last : 1'b0;
    in_valid1 = !gap1 && (src1.size() > 0);
    in_data1  = in_valid1 ? src1[0].data : '0;
    in_last1  = in_valid1 ? src1[0].last : 1'b0;
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      prev_ov   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (prev_ov && !prev_or) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_last", 32'(out_last), 32'(e.last));
          out_log.push_back(out_data);
        end
      end
      if (busy && !prev_busy) grant_log.push_back(sel);
      if (in_valid0 && in_ready0) exp_q.push_back(src0.pop_front());
      if (in_valid1 && in_ready1) exp_q.push_back(src1.pop_front());
      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_data = out_data;
      prev_busy = busy;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    gap0 = 1'b0;
    gap1 = 1'b0;
    src0.delete();
    src1.delete();
    cycle();
    reset = 1'b0;
    out_log.delete();
    grant_log.delete();
  endtask

  task automatic chk_log(input string name, input bit is_gnt);
    int n;
    n = is_gnt ? grant_log.size() : out_log.size();
    chk({name, "_len"}, 32'(n), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < n; i++) begin
      chk(name, is_gnt ? 32'(grant_log[i]) : out_log[i], want_q[i]);
    end
  endtask

  initial begin
    tbl[0] = '{v0: 1'b0, v1: 1'b0, exp_busy: 1'b0, exp_sel: 1'b0, exp_r0: 1'b0, exp_r1: 1'b0};
    tbl[1] = '{v0: 1'b1, v1: 1'b0, exp_busy: 1'b1, exp_sel: 1'b0, exp_r0: 1'b1, exp_r1: 1'b0};
    tbl[2] = '{v0: 1'b0, v1: 1'b1, exp_busy: 1'b1, exp_sel: 1'b1, exp_r0: 1'b0, exp_r1: 1'b1};
    tbl[3] = '{v0: 1'b1, v1: 1'b1, exp_busy: 1'b1, exp_sel: 1'b0, exp_r0: 1'b1, exp_r1: 1'b0};

    #1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready0", 32'(in_ready0), 32'd0);
    chk("rst_in_ready1", 32'(in_ready1), 32'd0);
    reset = 1'b0;

    // Arbitration from IDLE right after reset
    for (int i = 0; i < 4; i++) begin
      do_reset();
      if (tbl[i].v0) src0.push_back(mk(32'hE0 + i, 1'b1));
      if (tbl[i].v1) src1.push_back(mk(32'hF0 + i, 1'b1));
      cycle();
      chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      chk("tbl_sel", 32'(sel), 32'(tbl[i].exp_sel));
      chk("tbl_in_ready0", 32'(in_ready0), 32'(tbl[i].exp_r0));
      chk("tbl_in_ready1", 32'(in_ready1), 32'(tbl[i].exp_r1));
      repeat (7) cycle();
      chk("tbl_drained", 32'(exp_q.size() + src0.size() + src1.size()), 32'd0);
    end

    // Single requester, then priority moves to requester 1
    do_reset();
    src0.push_back(mk(32'hA0, 1'b0));
    src0.push_back(mk(32'hA1, 1'b0));
    src0.push_back(mk(32'hA2, 1'b1));
    cycle();
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_sel", 32'(sel), 32'd0);
    cycle();
    chk("single_d0", out_data, 32'hA0);
    chk("single_v0", 32'(out_valid), 32'd1);
    cycle();
    chk("single_d1", out_data, 32'hA1);
    chk("single_l1", 32'(out_last), 32'd0);
    cycle();
    chk("single_d2", out_data, 32'hA2);
    chk("single_l2", 32'(out_last), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);
    src0.push_back(mk(32'hB0, 1'b1));
    src1.push_back(mk(32'hC0, 1'b1));
    cycle();
    chk("prio_after_single_sel", 32'(sel), 32'd1);
    repeat (7) cycle();
    want_q = '{32'hA0, 32'hA1, 32'hA2, 32'hC0, 32'hB0};
    chk_log("single_out", 1'b0);

    // Tie and round-robin with 2-word bursts
    do_reset();
    for (int b = 0; b < 2; b++) begin
      src0.push_back(mk(32'h10 + 2 * b, 1'b0));
      src0.push_back(mk(32'h11 + 2 * b, 1'b1));
      src1.push_back(mk(32'h20 + 2 * b, 1'b0));
      src1.push_back(mk(32'h21 + 2 * b, 1'b1));
    end
    repeat (18) cycle();
    want_q = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h12, 32'h13, 32'h22, 32'h23};
    chk_log("rr_out", 1'b0);
    want_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    chk_log("rr_grant", 1'b1);

    // Backpressure during a requester 1 burst
    do_reset();
    src1.push_back(mk(32'h30, 1'b0));
    src1.push_back(mk(32'h31, 1'b0));
    src1.push_back(mk(32'h32, 1'b1));
    cycle();
    cycle();
    out_ready = 1'b0;
    repeat (4) cycle();
    chk("bp_in_ready1", 32'(in_ready1), 32'd0);
    chk("bp_out_data", out_data, 32'h30);
    chk("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    repeat (8) cycle();
    want_q = '{32'h30, 32'h31, 32'h32};
    chk_log("bp_out", 1'b0);

    // Burst cap forces release after MAX_BURST beats
    do_reset();
    for (int k = 0; k < 6; k++) src0.push_back(mk(32'h40 + k, 1'b0));
    src1.push_back(mk(32'h50, 1'b1));
    repeat (16) cycle();
    want_q = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h50, 32'h44, 32'h45};
    chk_log("cap_out", 1'b0);
    want_q = '{32'd0, 32'd1, 32'd0};
    chk_log("cap_grant", 1'b1);
    chk("cap_still_busy", 32'(busy), 32'd1);

    // Reset mid-burst clears grant, output stage and priority
    do_reset();
    src0.push_back(mk(32'h5F, 1'b1));
    repeat (4) cycle();
    src0.push_back(mk(32'h60, 1'b0));
    src0.push_back(mk(32'h61, 1'b0));
    src0.push_back(mk(32'h62, 1'b0));
    src0.push_back(mk(32'h63, 1'b1));
    repeat (3) cycle();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_data", out_data, 32'h61);
    do_reset();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_sel", 32'(sel), 32'd0);
    src0.push_back(mk(32'h70, 1'b1));
    src1.push_back(mk(32'h80, 1'b1));
    cycle();
    chk("mid_tie_sel", 32'(sel), 32'd0);
    chk("mid_tie_busy", 32'(busy), 32'd1);
    repeat (7) cycle();
    want_q = '{32'h70, 32'h80};
    chk_log("mid_out", 1'b0);

    // Requester 1 goes quiet mid-burst; grant is held
    do_reset();
    src1.push_back(mk(32'h90, 1'b0));
    src1.push_back(mk(32'h91, 1'b0));
    src1.push_back(mk(32'h92, 1'b1));
    cycle();
    cycle();
    gap1 = 1'b1;
    src0.push_back(mk(32'hA5, 1'b1));
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_sel", 32'(sel), 32'd1);
      chk("gap_in_ready0", 32'(in_ready0), 32'd0);
    end
    gap1 = 1'b0;
    repeat (10) cycle();
    want_q = '{32'h90, 32'h91, 32'h92, 32'hA5};
    chk_log("gap_out", 1'b0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
